// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite fetch arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, ARB, DRAIN)
//   - SPRITE_*    : default geometry used by the arbiter and its sub-module
//   - GRANT_CNT_W : width of each per-sprite grant counter (optional statistics
//                   enabled by the SPRITE_ARB_STATS_EN macro in the top level)
package sprite_pkg;

    localparam int SPRITE_N       = 6;
    localparam int SPRITE_ADDR_W  = 12;
    localparam int SPRITE_DATA_W  = 24;
    localparam int SPRITE_MEM_LAT = 2;
    localparam int GRANT_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Index width for a requester count; callers guarantee n >= 2.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_rr_select.sv
// Round-robin selector.
// Finds the first asserted request at or above ptr, wrapping from N-1 to 0.
// Ports:
//   req    in  N      request vector
//   ptr    in  IDX_W  search start index (0..N-1)
//   grant  out N      one-hot winner (all zero when no request)
//   winner out IDX_W  winner index (0 when no request)
module rr_select
    import sprite_pkg::*;
#(
    parameter int N     = SPRITE_N,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner
);

    int               k;
    logic [IDX_W-1:0] k_idx;

    // Scan offsets from the farthest to the nearest so the nearest hit to
    // ptr is the last one written and therefore wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        k      = 0;
        k_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            k_idx = IDX_W'(k);
            if (req[k_idx]) begin
                grant        = '0;
                grant[k_idx] = 1'b1;
                winner       = k_idx;
            end
        end
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Sprite fetch arbiter: N sprite engines share one read port of a sprite
// memory with fixed read latency MEM_LAT. One grant per cycle, round-robin.
//   gnt at t -> mem_rd_o/mem_addr_o at t+1 -> rvalid_o/rdata_o at t+2+MEM_LAT.
// Optional feature: define SPRITE_ARB_STATS_EN to add grant_cnt_o, a set of
// per-sprite 16-bit saturating grant counters.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en_i                  arbitration enable (low: finish in-flight reads)
//   req_i[N]              level requests, dropped the cycle after the grant
//   addr_i[N*ADDR_W]      per-sprite fetch address (sprite k at k*ADDR_W)
//   gnt_o[N]              one-hot grant, combinational
//   mem_rd_o, mem_addr_o  registered memory read strobe/address
//   mem_data_i            memory read data, valid MEM_LAT cycles after mem_rd_o
//   rvalid_o[N], rdata_o  registered one-hot return strobe and data
//   busy_o                high in ARB or DRAIN
//   grant_cnt_o[N*16]     (SPRITE_ARB_STATS_EN only) saturating grant counts
module sprite_fetch_arbiter
    import sprite_pkg::*;
#(
    parameter int N       = SPRITE_N,
    parameter int ADDR_W  = SPRITE_ADDR_W,
    parameter int DATA_W  = SPRITE_DATA_W,
    parameter int MEM_LAT = SPRITE_MEM_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [N-1:0]          req_i,
    input  logic [N*ADDR_W-1:0]   addr_i,
    output logic [N-1:0]          gnt_o,
    output logic                  mem_rd_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic [DATA_W-1:0]     mem_data_i,
    output logic [N-1:0]          rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
`ifdef SPRITE_ARB_STATS_EN
    output logic [N*GRANT_CNT_W-1:0] grant_cnt_o,
`endif
    output logic                  busy_o
);

    localparam int IDX_W = idx_width(N);

    arb_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [N-1:0]      rr_grant;
    logic [IDX_W-1:0]  rr_winner;
    logic              grant_en;
    logic              grant_fire;
    logic [ADDR_W-1:0] addr_arr [N];

    logic              mem_rd_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [N-1:0]      rvalid_reg, rvalid_next;
    logic [DATA_W-1:0] rdata_reg;

    // Tag pipeline: stage s holds the requester whose read was issued s+1
    // cycles ago; stage MEM_LAT lines up with valid mem_data_i.
    logic [MEM_LAT:0]  tag_vld_reg;
    logic [IDX_W-1:0]  tag_id_reg [MEM_LAT+1];
    logic              in_flight;

    genvar gi;

    // ------------------------------------------------------------------
    // Address unpacking
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < N; gi++) begin : g_addr
            assign addr_arr[gi] = addr_i[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    rr_select #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req    (req_i),
        .ptr    (rr_ptr_reg),
        .grant  (rr_grant),
        .winner (rr_winner)
    );

    // Grants stop in the same cycle en_i falls so DRAIN only has to wait
    // for reads that were already issued.
    assign grant_en   = (state_reg == ARB) && en_i;
    assign gnt_o      = grant_en ? rr_grant : '0;
    assign grant_fire = grant_en && (|req_i);
    assign in_flight  = |tag_vld_reg;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_fire) begin
            if (rr_winner == IDX_W'(N - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = rr_winner + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (en_i) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (!en_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (en_i) begin
                    state_next = ARB;
                end else if (!in_flight) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Memory request stage (address holds its last value between grants)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_reg   <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            mem_rd_reg <= grant_fire;
            if (grant_fire) begin
                mem_addr_reg <= addr_arr[rr_winner];
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_reg[0] <= 1'b0;
            tag_id_reg[0]  <= '0;
        end else begin
            tag_vld_reg[0] <= grant_fire;
            tag_id_reg[0]  <= rr_winner;
        end
    end

    generate
        for (gi = 1; gi <= MEM_LAT; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_vld_reg[gi] <= 1'b0;
                    tag_id_reg[gi]  <= '0;
                end else begin
                    tag_vld_reg[gi] <= tag_vld_reg[gi-1];
                    tag_id_reg[gi]  <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Return stage
    // ------------------------------------------------------------------
    always_comb begin
        rvalid_next = '0;
        if (tag_vld_reg[MEM_LAT]) begin
            rvalid_next[tag_id_reg[MEM_LAT]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= rvalid_next;
            if (tag_vld_reg[MEM_LAT]) begin
                rdata_reg <= mem_data_i;
            end
        end
    end

    assign mem_rd_o   = mem_rd_reg;
    assign mem_addr_o = mem_addr_reg;
    assign rvalid_o   = rvalid_reg;
    assign rdata_o    = rdata_reg;
    assign busy_o     = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Optional grant statistics
    // ------------------------------------------------------------------
`ifdef SPRITE_ARB_STATS_EN
    logic [GRANT_CNT_W-1:0] grant_cnt_reg [N];

    generate
        for (gi = 0; gi < N; gi++) begin : g_stats
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grant_cnt_reg[gi] <= '0;
                end else if (gnt_o[gi] && (grant_cnt_reg[gi] != {GRANT_CNT_W{1'b1}})) begin
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 1'b1;
                end
            end
            assign grant_cnt_o[gi*GRANT_CNT_W +: GRANT_CNT_W] = grant_cnt_reg[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed testbench for sprite_fetch_arbiter (N=6, ADDR_W=12, DATA_W=24,
// MEM_LAT=2). Inputs change 1 time unit after the rising edge; outputs are
// checked on the falling edge. The memory model returns f(addr) = {addr, ~addr}
// two cycles after mem_rd_o.
module tb_sprite_fetch_arbiter;

    localparam int N   = 6;
    localparam int AW  = 12;
    localparam int DW  = 24;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en_i;
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] addr_i;
    logic [N-1:0]    gnt_o;
    logic            mem_rd_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_data_i;
    logic [N-1:0]    rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            busy_o;
`ifdef SPRITE_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] addr_tab [N];
    logic [AW-1:0] p1 = '0;
    logic [AW-1:0] p2 = '0;

    sprite_fetch_arbiter #(
        .N       (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .gnt_o      (gnt_o),
        .mem_rd_o   (mem_rd_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
`ifdef SPRITE_ARB_STATS_EN
        .grant_cnt_o(grant_cnt_o),
`endif
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    // Two-cycle read latency memory model.
    always @(posedge clk) begin
        if (mem_rd_o) begin
            p1 <= mem_addr_o;
        end
        p2 <= p1;
    end
    assign mem_data_i = memf(p2);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("[%0t] %s obs=%h exp=%h ok", $time, tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant order of the continuous-request phase: slot -1 is the single
    // grant to sprite 5 that sets rr_ptr back to 0.
    function automatic int gseq(input int j);
        return (j < 0) ? 5 : (j % 6);
    endfunction

    initial begin
        int g;
        addr_tab[0] = 12'h0A0;
        addr_tab[1] = 12'h0B1;
        addr_tab[2] = 12'h123;
        addr_tab[3] = 12'h0D3;
        addr_tab[4] = 12'h0E4;
        addr_tab[5] = 12'h0F5;
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW] = addr_tab[k];
        end
        rst_n = 1'b0;
        en_i  = 1'b0;
        req_i = '0;

        // ---------------- reset state ----------------
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_gnt",    32'(gnt_o),      32'h0);
        chk("rst_mem_rd", 32'(mem_rd_o),   32'h0);
        chk("rst_addr",   32'(mem_addr_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o),   32'h0);
        chk("rst_rdata",  32'(rdata_o),    32'h0);
        chk("rst_busy",   32'(busy_o),     32'h0);

        // ---------------- single read, sprite 2 ----------------
        next_cycle(); rst_n = 1'b1; en_i = 1'b1; req_i = 6'b000100;
        @(negedge clk);
        chk("s1_idle_gnt",  32'(gnt_o),  32'h0);
        chk("s1_idle_busy", 32'(busy_o), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("s1_gnt",  32'(gnt_o),    32'h04);
        chk("s1_busy", 32'(busy_o),   32'h1);
        chk("s1_rd_t", 32'(mem_rd_o), 32'h0);
        next_cycle(); req_i = '0;
        @(negedge clk);
        chk("s1_rd_t1",   32'(mem_rd_o),   32'h1);
        chk("s1_addr_t1", 32'(mem_addr_o), 32'h123);
        chk("s1_gnt_t1",  32'(gnt_o),      32'h0);
        next_cycle();
        @(negedge clk);
        chk("s1_rd_t2",   32'(mem_rd_o),   32'h0);
        chk("s1_addr_t2", 32'(mem_addr_o), 32'h123);
        chk("s1_rv_t2",   32'(rvalid_o),   32'h0);
        next_cycle();
        @(negedge clk);
        chk("s1_rv_t3", 32'(rvalid_o), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("s1_rv_t4", 32'(rvalid_o), 32'h04);
        chk("s1_rd_t4", 32'(rdata_o),  32'(memf(12'h123)));
        next_cycle();
        @(negedge clk);
        chk("s1_rv_t5", 32'(rvalid_o), 32'h0);

        // ---------------- move rr_ptr to 5 (grant sprite 4) ----------------
        next_cycle(); req_i = 6'b010000;
        @(negedge clk);
        chk("p4_gnt", 32'(gnt_o), 32'h10);

        // ---------------- wrap: rr_ptr=5, req 100001 ----------------
        next_cycle(); req_i = 6'b100001;
        @(negedge clk);
        chk("wrap_gnt5", 32'(gnt_o), 32'h20);
        next_cycle(); req_i = 6'b000001;
        @(negedge clk);
        chk("wrap_gnt0",  32'(gnt_o),      32'h01);
        chk("wrap_addr5", 32'(mem_addr_o), 32'(addr_tab[5]));
        next_cycle(); req_i = '0;
        @(negedge clk);
        chk("wrap_idle",  32'(gnt_o),      32'h0);
        chk("wrap_rd0",   32'(mem_rd_o),   32'h1);
        chk("wrap_addr0", 32'(mem_addr_o), 32'(addr_tab[0]));

        // ---------------- rr_ptr -> 0 via sprite 5, then all requesting ----------------
        next_cycle(); req_i = 6'b100000;
        @(negedge clk);
        chk("p5_gnt", 32'(gnt_o), 32'h20);
        for (int i = 0; i <= 10; i++) begin
            next_cycle();
            req_i = (i <= 6) ? 6'b111111 : 6'b000000;
            @(negedge clk);
            chk($sformatf("all_gnt_%0d", i), 32'(gnt_o),
                (i <= 6) ? (32'h1 << (i % 6)) : 32'h0);
            chk($sformatf("all_rd_%0d", i), 32'(mem_rd_o), (i <= 7) ? 32'h1 : 32'h0);
            g = gseq(((i <= 7) ? i : 7) - 1);
            chk($sformatf("all_addr_%0d", i), 32'(mem_addr_o), 32'(addr_tab[g]));
            if (i >= 3) begin
                g = gseq(i - 4);
                chk($sformatf("all_rv_%0d", i), 32'(rvalid_o), 32'h1 << g);
                chk($sformatf("all_rdat_%0d", i), 32'(rdata_o), 32'(memf(addr_tab[g])));
            end
        end

        // ---------------- drain: two grants, then en_i low ----------------
        next_cycle(); req_i = 6'b000110;
        @(negedge clk);
        chk("dr_gnt1", 32'(gnt_o), 32'h02);
        next_cycle(); req_i = 6'b000100;
        @(negedge clk);
        chk("dr_gnt2", 32'(gnt_o), 32'h04);
        for (int c = 2; c <= 7; c++) begin
            next_cycle(); en_i = 1'b0; req_i = 6'b001000;
            @(negedge clk);
            chk($sformatf("dr_gnt_c%0d", c),  32'(gnt_o),  32'h0);
            chk($sformatf("dr_busy_c%0d", c), 32'(busy_o), (c <= 5) ? 32'h1 : 32'h0);
            chk($sformatf("dr_rv_c%0d", c),   32'(rvalid_o),
                (c == 4) ? 32'h02 : ((c == 5) ? 32'h04 : 32'h0));
            if (c == 4) chk("dr_rdat1", 32'(rdata_o), 32'(memf(addr_tab[1])));
            if (c == 5) chk("dr_rdat2", 32'(rdata_o), 32'(memf(addr_tab[2])));
            if (c >= 3) chk($sformatf("dr_rd_c%0d", c), 32'(mem_rd_o), 32'h0);
        end

        // ---------------- reset in the middle of a read ----------------
        next_cycle(); en_i = 1'b1;
        @(negedge clk);
        chk("mr_idle_gnt", 32'(gnt_o), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("mr_gnt", 32'(gnt_o), 32'h08);
        next_cycle(); req_i = '0;
        @(negedge clk);
        chk("mr_rd",   32'(mem_rd_o),   32'h1);
        chk("mr_addr", 32'(mem_addr_o), 32'(addr_tab[3]));
        next_cycle(); rst_n = 1'b0;
        #1;
        chk("mr_rst_gnt",  32'(gnt_o),      32'h0);
        chk("mr_rst_rd",   32'(mem_rd_o),   32'h0);
        chk("mr_rst_addr", 32'(mem_addr_o), 32'h0);
        chk("mr_rst_rv",   32'(rvalid_o),   32'h0);
        chk("mr_rst_rdat", 32'(rdata_o),    32'h0);
        chk("mr_rst_busy", 32'(busy_o),     32'h0);
        next_cycle();
        next_cycle(); rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("mr_post_rv_%0d", c), 32'(rvalid_o), 32'h0);
            chk($sformatf("mr_post_rd_%0d", c), 32'(mem_rd_o), 32'h0);
            next_cycle();
        end

`ifdef SPRITE_ARB_STATS_EN
        // ---------------- grant counter saturation ----------------
        req_i = 6'b000010;
        repeat (70001) next_cycle();
        req_i = '0;
        @(negedge clk);
        chk("cnt1_sat", 32'(grant_cnt_o[1*16 +: 16]), 32'h0000FFFF);
        chk("cnt0_zero", 32'(grant_cnt_o[0*16 +: 16]), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_arbiter.md
SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 SHALL have parameter N, default 6: number of sprite requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 12: sprite memory address width.
REQ-003 SHALL have parameter DATA_W, default 24: RGB word width.
REQ-004 SHALL have parameter MEM_LAT, default 2: cycles from mem_rd_o to valid mem_data_i (1..4).
REQ-005 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port en_i  in  1  arbitration enable; low requests drain.
REQ-008 SHALL have port req_i  in  N  per-sprite fetch request, level, held until granted.
REQ-009 SHALL have port addr_i  in  N x ADDR_W  per-sprite address, stable while req_i high.
REQ-010 SHALL have port gnt_o  out  N  one-hot grant pulse, combinational from current state.
REQ-011 SHALL have port mem_rd_o  out  1  shared memory read strobe, registered.
REQ-012 SHALL have port mem_addr_o  out  ADDR_W  shared memory address, registered.
REQ-013 SHALL have port mem_data_i  in  DATA_W  shared memory read data.
REQ-014 SHALL have port rvalid_o  out  N  one-hot read-return pulse to the granted sprite.
REQ-015 SHALL have port rdata_o  out  DATA_W  returned RGB word, registered, valid with rvalid_o.
REQ-016 SHALL have port busy_o  out  1  high in states ARB or DRAIN.

Function
REQ-017 SHALL implement states IDLE, ARB, DRAIN.
REQ-018 SHALL go IDLE->ARB when en_i=1; ARB->DRAIN when en_i=0; DRAIN->IDLE when no read in flight; DRAIN->ARB if en_i returns high.
REQ-019 SHALL grant only in ARB; gnt_o all-zero in IDLE and DRAIN.
REQ-020 SHALL pick winner as first index k with req_i[k]=1 searching from rr_ptr upward, wrapping N-1->0.
REQ-021 SHALL update rr_ptr to (winner+1) mod N on each grant; unchanged when no grant.
REQ-022 SHALL allow at most one grant per cycle, sustained throughput one read per cycle.
REQ-023 SHALL assert mem_rd_o and mem_addr_o=addr_i[winner] the cycle after gnt_o (t+1).
REQ-024 SHALL assert rvalid_o[winner] with rdata_o=mem_data_i registered at t+2+MEM_LAT.
REQ-025 SHALL track in-flight requester IDs in a MEM_LAT+1-deep tag pipeline; returns never reorder.
REQ-026 SHALL require requester to drop req_i the cycle after gnt_o; a req_i still high in the grant cycle+1 is a new request.
REQ-027 SHALL hold mem_addr_o at last value and mem_rd_o=0 when no grant.
REQ-028 SHALL complete all in-flight returns in DRAIN before IDLE; no return is dropped.

Reset
REQ-029 SHALL on rst_n=0 immediately force state IDLE, rr_ptr=0, gnt_o=0, mem_rd_o=0, mem_addr_o=0, rvalid_o=0, rdata_o=0, busy_o=0, tag pipeline cleared.
REQ-030 SHALL discard in-flight reads on reset mid-operation; no rvalid_o after release until new grants.

Configuration
REQ-031 SHALL with SPRITE_ARB_STATS_EN defined add output grant_cnt_o (N x 16): per-sprite saturating grant counters, cleared by reset, stuck at 16'hFFFF.
REQ-032 SHALL without SPRITE_ARB_STATS_EN omit grant_cnt_o and its counters; all other behaviour identical.

Structure
REQ-033 SHALL place state enum (IDLE, ARB, DRAIN) and default N, ADDR_W, DATA_W constants in package sprite_pkg.
REQ-034 SHALL implement round-robin selection in sub-module rr_select (inputs req, ptr; outputs one-hot grant, winner index).

Verification
REQ-035 Reset release, en_i=1, req_i=6'b000100, addr 0x123 -> gnt_o[2] at t, mem_addr_o=0x123 at t+1, rvalid_o[2] at t+4 (MEM_LAT=2).
REQ-036 All six req_i high continuously -> grants 0,1,2,3,4,5,0 on consecutive cycles, one mem_rd_o per cycle.
REQ-037 rr_ptr=5, req_i=6'b100001 -> grant 5 then 0 (wrap).
REQ-038 en_i dropped one cycle after two grants -> no further gnt_o, both rvalid_o returned, then busy_o=0.
REQ-039 rst_n low at t+2 of a read -> all outputs zero immediately, no rvalid_o after release.
REQ-040 With SPRITE_ARB_STATS_EN, 70000 grants to sprite 1 -> grant_cnt_o[1]=16'hFFFF.
